// File: rtl/eth_cmd_parser.sv
// eth_cmd_parser: filters RX command frames by dst MAC/EtherType and releases a decoded command after a clean frame end
//   clk125, reset         : clock, async active-high reset
//   rx_tdata/tvalid/tready/tlast/tuser : AXI-stream byte input from the MAC (tuser = frame error on tlast)
//   cmd, address, value   : committed command, held until ready4cmd
//   peer_mac              : source MAC of the last accepted command frame
//   good_cnt, drop_cnt    : accepted / discarded frame counters (wrapping)
module eth_cmd_parser #(
  parameter logic [47:0] MY_MAC    = 48'h02_00_00_00_00_01,
  parameter logic [15:0] ETHERTYPE = 16'h88B5
) (
  input  logic        clk125,
  input  logic        reset,
  input  logic [7:0]  rx_tdata,
  input  logic        rx_tvalid,
  output logic        rx_tready,
  input  logic        rx_tlast,
  input  logic        rx_tuser,
  output logic [2:0]  cmd,
  output logic [31:0] address,
  output logic [31:0] value,
  input  logic        ready4cmd,
  output logic [47:0] peer_mac,
  output logic [15:0] good_cnt,
  output logic [15:0] drop_cnt
);
  typedef enum logic [1:0] {RX, DROP, PEND} state_t;
  state_t state;
  logic [4:0] cnt;
  logic [2:0] sh_cmd;
  logic [31:0] sh_addr, sh_val;
  logic [47:0] sh_src;
  logic beat, bad;
  logic [7:0] dst_b, type_b;
  always_comb begin
    beat = rx_tvalid & rx_tready;
    dst_b = cnt == 5'd0 ? MY_MAC[47:40] : cnt == 5'd1 ? MY_MAC[39:32] : cnt == 5'd2 ? MY_MAC[31:24] :
            cnt == 5'd3 ? MY_MAC[23:16] : cnt == 5'd4 ? MY_MAC[15:8] : MY_MAC[7:0];
    type_b = cnt[0] ? ETHERTYPE[7:0] : ETHERTYPE[15:8];
    bad = (cnt < 5'd6 && rx_tdata != dst_b && rx_tdata != 8'hFF) ||
          ((cnt == 5'd12 || cnt == 5'd13) && rx_tdata != type_b) ||
          (cnt == 5'd14 && (rx_tdata[2:0] == 3'd0 || rx_tdata[2]));
  end
  always_ff @(posedge clk125 or posedge reset) begin
    if (reset) begin
      state <= RX;
      cnt <= '0;
      rx_tready <= 1'b1;
      cmd <= '0;
      address <= '0;
      value <= '0;
      peer_mac <= '0;
      good_cnt <= '0;
      drop_cnt <= '0;
      sh_cmd <= '0;
      sh_addr <= '0;
      sh_val <= '0;
      sh_src <= '0;
    end else begin
      if (beat) begin
        cnt <= rx_tlast ? 5'd0 : (cnt == 5'd26 ? cnt : cnt + 5'd1);
        if (cnt >= 5'd6 && cnt <= 5'd11) sh_src <= {sh_src[39:0], rx_tdata};
        if (cnt == 5'd14) sh_cmd <= rx_tdata[2:0];
        if (cnt >= 5'd18 && cnt <= 5'd21) sh_addr <= {sh_addr[23:0], rx_tdata};
        if (cnt >= 5'd22 && cnt <= 5'd25) sh_val <= {sh_val[23:0], rx_tdata};
      end
      case (state)
        RX: if (beat) begin
          if (rx_tlast && (bad || rx_tuser || cnt < 5'd25)) drop_cnt <= drop_cnt + 16'd1;
          else if (rx_tlast) begin
            // a 26-byte frame ends on the last value byte, which is not yet in the shadow
            cmd <= sh_cmd;
            address <= sh_addr;
            value <= cnt == 5'd25 ? {sh_val[23:0], rx_tdata} : sh_val;
            peer_mac <= sh_src;
            good_cnt <= good_cnt + 16'd1;
            rx_tready <= 1'b0;
            state <= PEND;
          end else if (bad) state <= DROP;
        end
        DROP: if (beat && rx_tlast) begin
          drop_cnt <= drop_cnt + 16'd1;
          state <= RX;
        end
        PEND: if (ready4cmd) begin
          cmd <= '0;
          rx_tready <= 1'b1;
          state <= RX;
        end
        default: state <= RX;
      endcase
    end
  end
endmodule
